// File: rtl/pwm_drive_monitor.sv
// rtl/pwm_drive_monitor.sv - L298 drive-line monitor: PWM period/high-time/duty, direction, stall and fault
module pwm_drive_monitor #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 65535
) (
    input  logic             W5,
    input  logic             rst_n,
    input  logic             pwm_in,
    input  logic             in1,
    input  logic             in2,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic [6:0]       duty_pct,
    output logic             meas_valid,
    output logic [1:0]       dir,
    output logic             stalled,
    output logic             fault
);

    localparam logic [1:0]       IDLE     = 2'd0;
    localparam logic [1:0]       MEASURE  = 2'd1;
    localparam int               DW       = CNT_W + 7;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TMO_END  = CNT_W'(TIMEOUT);

    logic             pwm_s1, pwm_s2, pwm_s3, edge_d;
    logic             in1_s1, in1_s2, in2_s1, in2_s2;
    logic [1:0]       state;
    logic [CNT_W-1:0] win_cnt, hi_cnt, tmo_cnt;
    logic             div_busy;
    logic [2:0]       div_step;
    logic [DW-1:0]    div_rem, div_sh;
    logic [6:0]       div_q;
    logic             stall_hit, div_ge;

    // An edge in the same cycle as the timeout always wins.
    assign stall_hit = !edge_d && (tmo_cnt == TMO_LAST);
    assign div_ge    = (div_rem >= div_sh);

    always_ff @(posedge W5 or negedge rst_n) begin
        if (!rst_n) begin
            pwm_s1 <= 1'b0;
            pwm_s2 <= 1'b0;
            pwm_s3 <= 1'b0;
            edge_d <= 1'b0;
            in1_s1 <= 1'b0;
            in1_s2 <= 1'b0;
            in2_s1 <= 1'b0;
            in2_s2 <= 1'b0;
            dir    <= 2'b00;
            fault  <= 1'b0;
        end else begin
            pwm_s1 <= pwm_in;
            pwm_s2 <= pwm_s1;
            pwm_s3 <= pwm_s2;
            edge_d <= pwm_s2 & ~pwm_s3;
            in1_s1 <= in1;
            in1_s2 <= in1_s1;
            in2_s1 <= in2;
            in2_s2 <= in2_s1;
            dir    <= {in2_s2, in1_s2};
            fault  <= in1_s2 & in2_s2 & pwm_s2;
        end
    end

    // Starts at 1 on an edge so stalled rises exactly TIMEOUT cycles after that edge cycle.
    always_ff @(posedge W5 or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (edge_d) begin
            tmo_cnt <= CNT_W'(1);
        end else if (tmo_cnt != TMO_END) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge W5 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            win_cnt    <= '0;
            hi_cnt     <= '0;
            period     <= '0;
            high_time  <= '0;
            duty_pct   <= 7'd0;
            meas_valid <= 1'b0;
            stalled    <= 1'b0;
            div_busy   <= 1'b0;
            div_step   <= 3'd0;
            div_rem    <= '0;
            div_sh     <= '0;
            div_q      <= 7'd0;
        end else begin
            meas_valid <= 1'b0;

            // Restoring divide, one quotient bit per cycle, then one cycle to publish.
            if (div_busy && !stall_hit) begin
                if (div_step == 3'd7) begin
                    duty_pct   <= div_q;
                    meas_valid <= 1'b1;
                    div_busy   <= 1'b0;
                end else begin
                    if (div_ge) begin
                        div_rem <= div_rem - div_sh;
                    end
                    div_q    <= {div_q[5:0], div_ge};
                    div_sh   <= div_sh >> 1;
                    div_step <= div_step + 3'd1;
                end
            end

            if (edge_d) begin
                stalled <= 1'b0;
                state   <= MEASURE;
                win_cnt <= CNT_W'(1);
                hi_cnt  <= CNT_W'(pwm_s3);
                if (state == MEASURE && !div_busy) begin
                    period    <= win_cnt;
                    high_time <= hi_cnt;
                    div_rem   <= DW'(hi_cnt) * DW'(100);
                    div_sh    <= DW'(win_cnt) << 6;
                    div_q     <= 7'd0;
                    div_step  <= 3'd0;
                    div_busy  <= 1'b1;
                end
            end else if (stall_hit) begin
                stalled    <= 1'b1;
                period     <= '0;
                high_time  <= '0;
                duty_pct   <= pwm_s3 ? 7'd100 : 7'd0;
                meas_valid <= 1'b1;
                div_busy   <= 1'b0;
                state      <= IDLE;
            end else if (state == MEASURE) begin
                if (win_cnt != CNT_MAX) begin
                    win_cnt <= win_cnt + CNT_W'(1);
                end
                if (pwm_s3 && hi_cnt != CNT_MAX) begin
                    hi_cnt <= hi_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_drive_monitor.sv
// tb/tb_pwm_drive_monitor.sv - randomized bench with edge-event reference model for pwm_drive_monitor
module tb_pwm_drive_monitor;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 2000;

    logic             clk    = 1'b0;
    logic             rst_n  = 1'b0;
    logic             pwm_in = 1'b0;
    logic             in1    = 1'b0;
    logic             in2    = 1'b0;
    logic [CNT_W-1:0] period, high_time;
    logic [6:0]       duty_pct;
    logic             meas_valid, stalled, fault;
    logic [1:0]       dir;

    int vectors     = 0;
    int miscompares = 0;

    pwm_drive_monitor #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .W5        (clk),
        .rst_n     (rst_n),
        .pwm_in    (pwm_in),
        .in1       (in1),
        .in2       (in2),
        .period    (period),
        .high_time (high_time),
        .duty_pct  (duty_pct),
        .meas_valid(meas_valid),
        .dir       (dir),
        .stalled   (stalled),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            if (miscompares <= 40)
                $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: works on the pin sample history and rising-edge events.
    typedef struct { int due; int duty; } pend_t;
    pend_t pend[$];
    int    p = -1, last_edge = 0, last_acc = -1000, win_start = 0, hi_run = 0;
    bit    measuring = 0, rise;
    logic [4:0]       h_pwm = '0, h_in1 = '0, h_in2 = '0;
    logic [CNT_W-1:0] exp_period = '0, exp_high = '0;
    logic [6:0]       exp_duty = '0;
    logic             exp_valid = 1'b0, exp_stalled = 1'b0, exp_fault = 1'b0;
    logic [1:0]       exp_dir = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p = -1; last_edge = 0; last_acc = -1000; win_start = 0; hi_run = 0; measuring = 0;
            h_pwm = '0; h_in1 = '0; h_in2 = '0;
            exp_period = '0; exp_high = '0; exp_duty = '0;
            exp_valid = 0; exp_stalled = 0; exp_fault = 0; exp_dir = '0;
            pend.delete();
        end else begin
            p++;
            h_pwm = {h_pwm[3:0], pwm_in};
            h_in1 = {h_in1[3:0], in1};
            h_in2 = {h_in2[3:0], in2};
            exp_dir   = {h_in2[2], h_in1[2]};
            exp_fault = h_in1[2] & h_in2[2] & h_pwm[2];
            exp_valid = 1'b0;
            if (pend.size() > 0 && pend[0].due == p) begin
                exp_duty  = 7'(pend[0].duty);
                exp_valid = 1'b1;
                void'(pend.pop_front());
            end
            rise = h_pwm[3] & ~h_pwm[4];
            if (rise) begin
                if (measuring && (p - last_acc) >= 9) begin
                    exp_period = CNT_W'(p - win_start);
                    exp_high   = CNT_W'(hi_run);
                    pend.push_back('{p + 8, (hi_run * 100) / (p - win_start)});
                    last_acc = p;
                end
                measuring = 1; exp_stalled = 0; win_start = p; hi_run = 1; last_edge = p;
            end else begin
                hi_run += int'(h_pwm[3]);
                if (p - last_edge == TIMEOUT - 1) begin
                    exp_stalled = 1; exp_period = '0; exp_high = '0;
                    exp_duty  = h_pwm[3] ? 7'd100 : 7'd0;
                    exp_valid = 1'b1;
                    measuring = 0;
                    pend.delete();
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("period",     32'(period),    32'(exp_period));
        chk("high_time",  32'(high_time), 32'(exp_high));
        chk("duty_pct",   32'(duty_pct),  32'(exp_duty));
        chk("meas_valid", 32'(meas_valid), 32'(exp_valid));
        chk("dir",        32'(dir),       32'(exp_dir));
        chk("stalled",    32'(stalled),   32'(exp_stalled));
        chk("fault",      32'(fault),     32'(exp_fault));
    end

    int nvalid = 0;
    logic [CNT_W-1:0] cap_period = '0, cap_high = '0;
    logic [6:0]       cap_duty = '0;
    always @(negedge clk) begin
        if (meas_valid === 1'b1) begin
            nvalid++;
            cap_period = period;
            cap_high   = high_time;
            cap_duty   = duty_pct;
        end
    end

    task automatic run_pwm(input int per, input int hi, input int n);
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < per; j++) begin
                @(negedge clk);
                pwm_in = (j < hi);
            end
        end
    endtask

    task automatic chk_result(input string name, input int n0, input int per, input int hi, input int duty);
        #1;
        chk({name, "_fresh"},  32'(nvalid > n0), 32'd1);
        chk({name, "_period"}, 32'(cap_period), 32'(per));
        chk({name, "_high"},   32'(cap_high),   32'(hi));
        chk({name, "_duty"},   32'(cap_duty),   32'(duty));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, per, hi;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_period", 32'(period), 0);
        chk("rst_high", 32'(high_time), 0);
        chk("rst_duty", 32'(duty_pct), 0);
        chk("rst_valid", 32'(meas_valid), 0);
        chk("rst_dir", 32'(dir), 0);
        chk("rst_stalled", 32'(stalled), 0);
        chk("rst_fault", 32'(fault), 0);
        @(negedge clk);
        rst_n = 1'b1; in1 = 1'b1; in2 = 1'b0;

        n0 = nvalid;
        run_pwm(256, 64, 4);
        chk_result("p256", n0, 256, 64, 25);
        chk("p256_dir", 32'(dir), 32'd1);
        chk("p256_fault", 32'(fault), 0);

        n0 = nvalid;
        run_pwm(300, 100, 4);
        chk_result("p300", n0, 300, 100, 33);

        n0 = nvalid;
        run_pwm(200, 199, 4);
        chk_result("p200", n0, 200, 199, 99);

        @(negedge clk);
        pwm_in = 1'b1;
        repeat (100) @(negedge clk);
        #1 n0 = nvalid;
        repeat (2400) @(negedge clk);
        #1;
        chk("stall_pulses", 32'(nvalid - n0), 32'd1);
        chk("stall_flag", 32'(stalled), 32'd1);
        chk("stall_period", 32'(cap_period), 0);
        chk("stall_high", 32'(cap_high), 0);
        chk("stall_duty", 32'(cap_duty), 32'd100);
        @(negedge clk);
        pwm_in = 1'b0;
        repeat (10) @(negedge clk);
        n0 = nvalid;
        run_pwm(256, 64, 1);
        #1;
        chk("resume_clear", 32'(stalled), 0);
        chk("resume_no_result", 32'(nvalid - n0), 0);
        n0 = nvalid;
        run_pwm(256, 64, 2);
        chk_result("resume", n0, 256, 64, 25);

        n0 = nvalid;
        run_pwm(6, 3, 60);
        chk_result("p6", n0, 6, 3, 50);
        chk("p6_rate", 32'((nvalid - n0) <= 41), 32'd1);

        in1 = 1'b1; in2 = 1'b1;
        run_pwm(20, 10, 6);
        #1 chk("brake_dir", 32'(dir), 32'd3);
        in1 = 1'b0; in2 = 1'b1;
        run_pwm(20, 10, 4);
        #1;
        chk("rev_dir", 32'(dir), 32'd2);
        chk("rev_fault", 32'(fault), 0);

        for (int k = 0; k < 30; k++) begin
            per = (k % 5 == 0) ? int'($urandom_range(4, 12)) : int'($urandom_range(9, 300));
            hi  = int'($urandom_range(1, per - 1));
            in1 = 1'($urandom_range(0, 1));
            in2 = 1'($urandom_range(0, 1));
            run_pwm(per, hi, int'($urandom_range(1, 3)));
        end

        run_pwm(100, 50, 2);
        repeat (20) @(negedge clk);
        @(negedge clk);
        pwm_in = 1'b1;
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n0 = nvalid;
        chk("arst_period", 32'(period), 0);
        chk("arst_high", 32'(high_time), 0);
        chk("arst_duty", 32'(duty_pct), 0);
        chk("arst_valid", 32'(meas_valid), 0);
        chk("arst_dir", 32'(dir), 0);
        chk("arst_stalled", 32'(stalled), 0);
        repeat (4) @(negedge clk);
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        run_pwm(256, 64, 1);
        #1 chk("arst_no_result", 32'(nvalid - n0), 0);
        n0 = nvalid;
        run_pwm(256, 64, 2);
        chk_result("arst_after", n0, 256, 64, 25);

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
